axi_llc_way_arb: RTL and testbench
==================================

// Module: axi_llc_way_arb
//
// PURPOSE
// - Per-data-way request scheduler: arbitrates the four LLC units (Evict, Refill, WChan, RChan) onto one
//   axi_llc_data_way input. One instance sits in front of each way.
// - Fair round-robin with anti-starvation aging and AXI-style lock-in.
// - Read-credit tracking: read requests never exceed the way's response buffering.
//
// PARAMETERS
// - NumUnits        4                                   number of requesting units
// - MaxRdOutstanding axi_llc_pkg::DataMacroLatency + 1  read credits (unconsumed read responses allowed)
// - StarveThresh    8                                   waiting cycles before a unit becomes starved
// - way_inp_t       logic                               request payload type (same as data way input)
//
// PORTS
// - clk_i           in   1              clock, rising edge
// - rst_i           in   1              synchronous reset, active-high
// - req_i           in   NumUnits x way_inp_t  request payload per unit
// - req_is_read_i   in   NumUnits       request consumes a read credit
// - req_valid_i     in   NumUnits       request valid
// - req_ready_o     out  NumUnits       request accepted by way
// - way_o           out  way_inp_t      payload to data way
// - way_valid_o     out  1              payload valid
// - way_ready_i     in   1              data way ready
// - gnt_idx_o       out  $clog2(NumUnits)  index of unit currently driving way_o
// - rd_done_i       in   1              one read response left the way (handshake on way output)
// - credits_o       out  $clog2(MaxRdOutstanding+1)  free read credits
//
// BEHAVIOUR
// - Reset (rst_i high at a rising edge): rr pointer=0; all age counters=0; lock=0;
//   credits=MaxRdOutstanding. Outputs at reset: req_ready_o=0, way_valid_o=0, gnt_idx_o=0, way_o='0.
// - Eligible unit: req_valid_i high AND (req_is_read_i low OR credits>0).
// - States: IDLE, LOCKED.
//   - IDLE: choose the winner among eligible units.
//     - Starved units (age==StarveThresh) win first; lowest index among them.
//     - Otherwise, round-robin starting at rr pointer.
//     - Drive way_o=req_i[win], way_valid_o=1, req_ready_o[win]=way_ready_i.
//     - Handshake: stay IDLE, pointer := win+1 (mod NumUnits).
//     - No handshake: go to LOCKED, storing win.
//   - LOCKED: output the stored unit unconditionally (no re-arbitration, credits not re-checked).
//     - Handshake: return to IDLE and advance the pointer.
//     - The requester must hold valid and payload (AXI rule); dropping valid is an error.
// - Latency: combinational, zero cycles from req to way; no payload register.
// - Aging: each cycle a unit is valid and does not handshake, its age increments, saturating at
//   StarveThresh. On handshake its age clears to 0. If not valid, age clears to 0.
// - Credits: decrement on a read handshake; increment on rd_done_i. Both in the same cycle: unchanged.
//   - credits==0: read requests are ineligible; writes/refills still flow.
//   - rd_done_i at credits==MaxRdOutstanding is an error and is ignored (saturate).
// - Reset mid-operation: lock and credits are discarded; the outstanding way responses are
//   the caller's responsibility (the whole LLC resets together).
// - No eligible unit: way_valid_o=0, state unchanged.
//
// CONFIGURATION
// - AXI_LLC_WAY_ARB_PERF_EN defined: adds ports
//   - stall_cycles_o out 32: saturating count of cycles with way_valid_o & ~way_ready_i.
//   - starve_events_o out 16: saturating count of starved-unit grants.
//   - Both counters clear on rst_i.
// - Undefined: ports absent, no counters synthesised.
//
// STRUCTURE
// - axi_llc_pkg: add typedef way_arb_state_e {ArbIdle, ArbLocked} and localparam WayArbStarveThresh.
// - Sub-module axi_llc_way_arb_credit: up/down saturating credit counter
//   (inc_i, dec_i, credits_o, empty_o).
// - Arbitration, aging and lock logic live in the top module.
//
// TESTING
// - Reset, then all 4 valid, way_ready_i=1 -> grants 0,1,2,3,0; credits track reads;
//   no output is X after reset.
// - Unit 2 valid, way_ready_i=0 for 5 cycles while unit 0 also asserts valid
//   -> gnt_idx_o stays 2, way_o stable; unit 2 handshakes on cycle 6.
// - MaxRdOutstanding=2, RChan issues 3 reads, no rd_done_i -> 2 accepted, credits_o=0,
//   3rd read held; WChan write still granted; one rd_done_i pulse -> 3rd read accepted next cycle.
// - Same-cycle read handshake and rd_done_i at credits=1 -> credits_o stays 1.
// - Units 0,1 valid continuously, unit 3 valid with way ready 1 of every 3 cycles
//   -> unit 3 granted no later than StarveThresh=8 waiting cycles.
// - rst_i asserted while LOCKED with credits=0 -> next cycle way_valid_o=0 and credits_o=2.
// - PERF_EN build: 4 stall cycles -> stall_cycles_o=4.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// Shared LLC definitions: data macro latency and way-arbiter state/aging constants.
package axi_llc_pkg;

    localparam int unsigned DataMacroLatency   = 1;
    localparam int unsigned WayArbStarveThresh = 8;

    typedef enum logic [0:0] {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } way_arb_state_e;

endpackage

// File: rtl/axi_llc_way_arb_credit.sv
// Up/down saturating read-credit counter guarding the data way's response buffering.
module axi_llc_way_arb_credit #(
    parameter  int unsigned MaxCredits = 2,
    localparam int unsigned CntW       = $clog2(MaxCredits + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] credits_o,
    output logic            empty_o
);

    logic [CntW-1:0] cnt_q;

    // A return and a consumption in the same cycle cancel; stray returns at full are dropped.
    function automatic logic [CntW-1:0] sat_step(input logic [CntW-1:0] cnt,
                                                 input logic inc, input logic dec);
        if (inc && !dec) return (cnt == CntW'(MaxCredits)) ? cnt : cnt + CntW'(1);
        if (dec && !inc) return (cnt == '0) ? cnt : cnt - CntW'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CntW'(MaxCredits);
        end else begin
            cnt_q <= sat_step(cnt_q, inc_i, dec_i);
        end
    end

    assign credits_o = cnt_q;
    assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/axi_llc_way_arb.sv
// Per-way scheduler for the LLC units: round-robin with aging, AXI lock-in and read credits.
// Optional performance counters are enabled by defining AXI_LLC_WAY_ARB_PERF_EN.
module axi_llc_way_arb
    import axi_llc_pkg::*;
#(
    parameter  int unsigned NumUnits         = 4,
    parameter  int unsigned MaxRdOutstanding = DataMacroLatency + 1,
    parameter  int unsigned StarveThresh     = WayArbStarveThresh,
    parameter  type         way_inp_t        = logic,
    localparam int unsigned IdxW             = $clog2(NumUnits),
    localparam int unsigned CredW            = $clog2(MaxRdOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  way_inp_t [NumUnits-1:0] req_i,
    input  logic [NumUnits-1:0]     req_is_read_i,
    input  logic [NumUnits-1:0]     req_valid_i,
    output logic [NumUnits-1:0]     req_ready_o,
    output way_inp_t                way_o,
    output logic                    way_valid_o,
    input  logic                    way_ready_i,
    output logic [IdxW-1:0]         gnt_idx_o,
    input  logic                    rd_done_i,
    output logic [CredW-1:0]        credits_o
`ifdef AXI_LLC_WAY_ARB_PERF_EN
    ,
    output logic [31:0]             stall_cycles_o,
    output logic [15:0]             starve_events_o
`endif
);

    localparam int unsigned     AgeW   = $clog2(StarveThresh + 1);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(StarveThresh);

    way_arb_state_e      state_q;
    logic [IdxW-1:0]     ptr_q;
    logic [IdxW-1:0]     lock_q;
    logic [IdxW-1:0]     win;
    logic [AgeW-1:0]     age_q [NumUnits];
    logic [NumUnits-1:0] eligible;
    logic [NumUnits-1:0] starved;
    logic [NumUnits-1:0] rr_mask;
    logic [NumUnits-1:0] hi_elig;
    logic                arb_valid;
    logic                handshake;
    logic                rd_handshake;
    logic                cred_empty;

    function automatic logic [IdxW-1:0] first_set(input logic [NumUnits-1:0] vec);
        first_set = '0;
        for (int i = NumUnits - 1; i >= 0; i--) begin
            if (vec[i]) first_set = IdxW'(i);
        end
    endfunction

    function automatic logic [AgeW-1:0] age_step(input logic [AgeW-1:0] age,
                                                 input logic valid, input logic served);
        if (!valid || served) return '0;
        return (age == AgeMax) ? age : age + AgeW'(1);
    endfunction

    function automatic logic [IdxW-1:0] idx_wrap_inc(input logic [IdxW-1:0] idx);
        return (idx == IdxW'(NumUnits - 1)) ? '0 : idx + IdxW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NumUnits; i++) begin
            eligible[i] = req_valid_i[i] & (~req_is_read_i[i] | ~cred_empty);
            starved[i]  = eligible[i] & (age_q[i] == AgeMax);
        end
        // Units at or above the pointer get first pick; the rest wrap around.
        rr_mask = ~((NumUnits'(1) << ptr_q) - NumUnits'(1));
        hi_elig = eligible & rr_mask;
    end

    always_comb begin
        arb_valid = 1'b0;
        win       = '0;
        if (!rst_i) begin
            if (state_q == ArbLocked) begin
                arb_valid = 1'b1;
                win       = lock_q;
            end else if (|starved) begin
                arb_valid = 1'b1;
                win       = first_set(starved);
            end else if (|hi_elig) begin
                arb_valid = 1'b1;
                win       = first_set(hi_elig);
            end else if (|eligible) begin
                arb_valid = 1'b1;
                win       = first_set(eligible);
            end
        end
        req_ready_o = '0;
        if (arb_valid) req_ready_o[win] = way_ready_i;
    end

    assign handshake    = arb_valid & way_ready_i;
    assign rd_handshake = handshake & req_is_read_i[win];
    assign way_valid_o  = arb_valid;
    assign gnt_idx_o    = win;
    assign way_o        = arb_valid ? req_i[win] : way_inp_t'('0);

    axi_llc_way_arb_credit #(
        .MaxCredits (MaxRdOutstanding)
    ) i_credit (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (rd_done_i),
        .dec_i     (rd_handshake),
        .credits_o (credits_o),
        .empty_o   (cred_empty)
    );

    // A grant that is not taken holds the way until the requester handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ArbIdle;
            ptr_q   <= '0;
            lock_q  <= '0;
            for (int i = 0; i < NumUnits; i++) age_q[i] <= '0;
        end else begin
            if (arb_valid) begin
                if (way_ready_i) begin
                    state_q <= ArbIdle;
                    ptr_q   <= idx_wrap_inc(win);
                end else begin
                    state_q <= ArbLocked;
                    lock_q  <= win;
                end
            end
            for (int i = 0; i < NumUnits; i++) begin
                age_q[i] <= age_step(age_q[i], req_valid_i[i], handshake && (win == IdxW'(i)));
            end
        end
    end

`ifdef AXI_LLC_WAY_ARB_PERF_EN
    logic starve_grant;

    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
        return (cnt == '1) ? cnt : cnt + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == '1) ? cnt : cnt + 16'd1;
    endfunction

    assign starve_grant = handshake & (age_q[win] == AgeMax);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o  <= '0;
            starve_events_o <= '0;
        end else begin
            if (arb_valid && !way_ready_i) stall_cycles_o <= sat_inc32(stall_cycles_o);
            if (starve_grant) starve_events_o <= sat_inc16(starve_events_o);
        end
    end
`endif

endmodule

// File: tb/tb_axi_llc_way_arb.sv
// Bench for axi_llc_way_arb: directed vector table, corner sequences and a randomized model run.
module tb_axi_llc_way_arb;

    localparam int NU   = 4;
    localparam int MAXC = 2;
    localparam int THR  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0][7:0]  req = '0;
    logic [3:0]       is_read = '0;
    logic [3:0]       valid = '0;
    logic [3:0]       req_ready;
    logic [7:0]       way_data;
    logic             way_valid;
    logic             way_ready = 1'b0;
    logic [1:0]       gnt_idx;
    logic             rd_done = 1'b0;
    logic [1:0]       credits;
`ifdef AXI_LLC_WAY_ARB_PERF_EN
    logic [31:0]      stall_cycles;
    logic [15:0]      starve_events;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_ptr = 0;
    int m_lock_idx = 0;
    int m_cred = MAXC;
    int m_age [NU] = '{default: 0};
    bit m_locked = 1'b0;

    always #5 clk = ~clk;

    axi_llc_way_arb #(
        .way_inp_t (logic [7:0])
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .req_is_read_i (is_read),
        .req_valid_i   (valid),
        .req_ready_o   (req_ready),
        .way_o         (way_data),
        .way_valid_o   (way_valid),
        .way_ready_i   (way_ready),
        .gnt_idx_o     (gnt_idx),
        .rd_done_i     (rd_done),
        .credits_o     (credits)
`ifdef AXI_LLC_WAY_ARB_PERF_EN
        ,
        .stall_cycles_o  (stall_cycles),
        .starve_events_o (starve_events)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] rd;
        logic       rdy;
        logic       done;
        logic       e_vld;
        logic [1:0] e_gnt;
        logic [3:0] e_rdy;
        logic [1:0] e_cred;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Winner from the rules: a held grant, else lowest starved eligible unit, else scan from pointer.
    function automatic void model_out(output bit ev, output int w);
        bit elig [NU];
        ev = 1'b0;
        w  = 0;
        if (rst) return;
        if (m_locked) begin
            ev = 1'b1;
            w  = m_lock_idx;
            return;
        end
        for (int i = 0; i < NU; i++) elig[i] = valid[i] && (!is_read[i] || m_cred > 0);
        for (int i = 0; i < NU; i++) begin
            if (elig[i] && m_age[i] == THR) begin
                ev = 1'b1;
                w  = i;
                return;
            end
        end
        for (int k = 0; k < NU; k++) begin
            int j;
            j = (m_ptr + k) % NU;
            if (elig[j]) begin
                ev = 1'b1;
                w  = j;
                return;
            end
        end
    endfunction

    function automatic void model_update();
        bit ev;
        int w;
        bit hs;
        bit take;
        if (rst) begin
            m_ptr = 0;
            m_locked = 1'b0;
            m_lock_idx = 0;
            m_cred = MAXC;
            for (int i = 0; i < NU; i++) m_age[i] = 0;
            return;
        end
        model_out(ev, w);
        hs = ev && way_ready;
        for (int i = 0; i < NU; i++) begin
            if (!valid[i] || (hs && w == i)) m_age[i] = 0;
            else if (m_age[i] < THR) m_age[i]++;
        end
        if (ev) begin
            if (hs) begin
                m_locked = 1'b0;
                m_ptr = (w + 1) % NU;
            end else begin
                m_locked = 1'b1;
                m_lock_idx = w;
            end
        end
        take = hs && is_read[w];
        if (take && !rd_done && m_cred > 0) m_cred--;
        else if (rd_done && !take && m_cred < MAXC) m_cred++;
    endfunction

    task automatic tick();
        model_update();
        @(negedge clk);
    endtask

    task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] rd,
                         input logic rdy, input logic dn);
        rst = r;
        valid = v;
        is_read = rd;
        way_ready = rdy;
        rd_done = dn;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [1:0] eg,
                              input logic [3:0] er, input int ec);
        logic [7:0] ew;
        #1;
        ew = ev ? req[eg] : 8'h00;
        check({tag, " ctl"}, {61'd0, way_valid, gnt_idx, req_ready}, {61'd0, ev, eg, er});
        check({tag, " way"}, {56'd0, way_data}, {56'd0, ew});
        check({tag, " cred"}, {62'd0, credits}, {62'd0, ec[1:0]});
    endtask

    task automatic check_model(input string tag);
        bit ev;
        int w;
        logic [3:0] er;
        model_out(ev, w);
        er = '0;
        if (ev) er[w] = way_ready;
        expect_out(tag, ev, 2'(w), er, m_cred);
    endtask

    task automatic do_reset();
        apply(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int max_wait;
        int wait_cnt;
        int grants3;

        //         rst   vld    rd     rdy   done  e_vld e_gnt e_rdy  e_cred
        tbl[0]  = '{1'b1, 4'hF, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 2'd2};
        tbl[1]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 2'd2};
        tbl[2]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd1, 4'h2, 2'd2};
        tbl[3]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd2, 4'h4, 2'd1};
        tbl[4]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd3, 4'h8, 2'd1};
        tbl[5]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 2'd1};
        tbl[6]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd1, 4'h2, 2'd1};
        tbl[7]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd2, 4'h4, 2'd0};
        tbl[8]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd3, 4'h8, 2'd0};
        tbl[9]  = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 2'd0};
        tbl[10] = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd2, 4'h4, 2'd0};
        tbl[11] = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b1, 1'b1, 2'd3, 4'h8, 2'd0};
        tbl[12] = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 2'd1};
        tbl[13] = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1, 2'd1, 4'h2, 2'd1};
        tbl[14] = '{1'b0, 4'hF, 4'h2, 1'b1, 1'b1, 1'b1, 2'd2, 4'h4, 2'd0};
        tbl[15] = '{1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 2'd1};
        tbl[16] = '{1'b0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 2'd1};

        for (int i = 0; i < NU; i++) req[i] = 8'hA0 + 8'(i);
        do_reset();

        for (int r = 0; r < 17; r++) begin
            apply(tbl[r].rst, tbl[r].vld, tbl[r].rd, tbl[r].rdy, tbl[r].done);
            expect_out($sformatf("tbl%0d", r), tbl[r].e_vld, tbl[r].e_gnt, tbl[r].e_rdy,
                       int'(tbl[r].e_cred));
            tick();
        end

        // Lock-in: unit 2 holds the way while unit 0 waits.
        do_reset();
        req[2] = 8'h5A;
        req[0] = 8'h33;
        apply(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
        expect_out("lock_first", 1'b1, 2'd2, 4'b0000, 2);
        tick();
        for (int k = 1; k < 5; k++) begin
            apply(1'b0, 4'b0101, 4'b0000, 1'b0, 1'b0);
            expect_out($sformatf("lock_hold%0d", k), 1'b1, 2'd2, 4'b0000, 2);
            tick();
        end
        apply(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0);
        expect_out("lock_release", 1'b1, 2'd2, 4'b0100, 2);
        tick();
        apply(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0);
        expect_out("lock_next", 1'b1, 2'd0, 4'b0001, 2);
        tick();

        // Credits: RChan reads exhaust credits, WChan write still flows, one return re-enables.
        do_reset();
        apply(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
        expect_out("cr_read1", 1'b1, 2'd3, 4'b1000, 2);
        tick();
        expect_out("cr_read2", 1'b1, 2'd3, 4'b1000, 1);
        tick();
        expect_out("cr_read3_held", 1'b0, 2'd0, 4'b0000, 0);
        tick();
        apply(1'b0, 4'b1100, 4'b1000, 1'b1, 1'b0);
        expect_out("cr_write", 1'b1, 2'd2, 4'b0100, 0);
        tick();
        apply(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1);
        expect_out("cr_done", 1'b0, 2'd0, 4'b0000, 0);
        tick();
        apply(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0);
        expect_out("cr_resume", 1'b1, 2'd3, 4'b1000, 1);
        tick();

        // Reset while locked with no credits.
        apply(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
        expect_out("rl_lock", 1'b1, 2'd2, 4'b0000, 0);
        tick();
        apply(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_out("rl_in_reset", 1'b0, 2'd0, 4'b0000, 0);
        tick();
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        expect_out("rl_after", 1'b0, 2'd0, 4'b0000, 2);
        tick();

        // Starvation bound: units 0,1 always valid, way ready one cycle in three.
        do_reset();
        max_wait = 0;
        wait_cnt = 0;
        grants3 = 0;
        for (int c = 0; c < 30; c++) begin
            apply(1'b0, 4'b1011, 4'b0000, (c % 3) == 2, 1'b0);
            check_model("starve");
            if (req_ready[3]) begin
                grants3++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            tick();
        end
        check("starve_wait_bound", 64'(max_wait <= THR), 64'd1);
        check("starve_unit3_granted", 64'(grants3 > 0), 64'd1);

`ifdef AXI_LLC_WAY_ARB_PERF_EN
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
            expect_out("perf_stall", 1'b1, 2'd0, 4'b0000, 2);
            tick();
        end
        apply(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0);
        expect_out("perf_hs", 1'b1, 2'd0, 4'b0001, 2);
        tick();
        apply(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        #1;
        check("perf_stall_cycles", 64'(stall_cycles), 64'd4);
        check("perf_starve_events", 64'(starve_events), 64'd0);
        tick();
`endif

        // Randomized traffic against the reference model; the locked requester holds its request.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NU; i++) begin
                if (!(m_locked && m_lock_idx == i)) begin
                    valid[i]   = ($urandom_range(0, 9) < 6);
                    is_read[i] = ($urandom_range(0, 1) == 1);
                    req[i]     = 8'($urandom);
                end
            end
            way_ready = ($urandom_range(0, 3) != 0);
            rd_done   = ($urandom_range(0, 2) == 0);
            check_model("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
